// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor (a - b, LSB first) with a start/done handshake.
// Computes one bit per clock; the result, borrow and zero flags hold until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_start,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  output logic             io_busy,
  output logic             io_done,
  output logic [WIDTH-1:0] io_c,
  output logic             io_borrow,
  output logic             io_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("serial_subtractor: WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] sr_next;
  logic             accept;

  // Full-subtractor slice for the current bit; sr_next already contains this bit's difference.
  // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
  always_comb begin
    a0      = sa[0];
    b0      = sb[0];
    d       = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~a0 & br) | (b0 & br);
    sr_next = {d, sr[WIDTH-1:1]};
    accept  = io_start && (state != RUN);
  end

  // NOTE: state and outputs use non-blocking assignments so every register updates from
  // pre-edge values, which keeps simulation and synthesis in agreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      sr        <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      io_busy   <= 1'b0;
      io_done   <= 1'b0;
      io_c      <= '0;
      io_borrow <= 1'b0;
      io_zero   <= 1'b0;
    end else begin
      io_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sa      <= io_a;
            sb      <= io_b;
            br      <= 1'b0;
            cnt     <= '0;
            state   <= RUN;
            io_busy <= 1'b1;
          end else begin
            state   <= IDLE;
            io_busy <= 1'b0;
          end
        end

        RUN: begin
          sr  <= sr_next;
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + 1'b1;
          // Last bit: publish the finished result; io_start is ignored throughout RUN.
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            io_busy   <= 1'b0;
            io_done   <= 1'b1;
            io_c      <= sr_next;
            io_borrow <= br_next;
            io_zero   <= (sr_next == '0);
          end
        end

        default: begin
          state   <= IDLE;
          io_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
